// File: rtl/sram_scan_reader.sv
// sram_scan_reader: walks a contiguous SPRAM address range through the
// arbiter's level-request / strobe-completion handshake and buffers the
// returned words in a small FIFO for a valid/ready consumer.
// One read outstanding at most; a request is only raised when the FIFO
// can take its result.
// Optional build macro: SCAN_READER_LOOP_EN -- rescan from base forever
// until stop, instead of a single pass.
module sram_scan_reader #(
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] length,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic                         read_request,
  input  logic                         read_finished_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic [DATA_BUS_WIDTH-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STALL, S_DRAIN, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [ADDRESS_BUS_WIDTH-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
  logic                         req_q, req_d;
  logic [DATA_BUS_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                count_q;

  logic                         push, pop, full_next, room_now;
  logic [ADDRESS_BUS_WIDTH-1:0] idx_inc;
  logic                         last;

  assign pop       = out_valid && out_ready;
  // FIFO would be full after a push this edge, given any same-cycle pop
  assign full_next = (count_q == CW'(FIFO_DEPTH - 1)) && !pop;
  assign room_now  = (count_q != CW'(FIFO_DEPTH)) || pop;
  assign idx_inc   = idx_q + 1'b1;
  assign last      = (idx_inc == len_q);

  assign read_request = req_q;
  assign read_address = base_q + idx_q;   // wraps naturally at the top of memory
  assign out_data     = mem_q[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

  // State, scan registers and the request flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
    end
  end

  // Next-state: request is re-armed one cycle after each completion so it
  // is always low for at least one cycle between reads
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    req_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = start_address;
          len_d  = length;
          idx_d  = '0;
          if (length == '0) begin
            state_d = S_DONE;
          end else if (room_now) begin
            state_d = S_ISSUE;
            req_d   = 1'b1;
          end else begin
            state_d = S_STALL;
          end
        end
      end
      S_ISSUE: begin
        if (!req_q) begin
          // gap cycle after a completion: nothing outstanding
          if (stop) state_d = S_DONE;
          else      req_d   = 1'b1;
        end else if (read_finished_strobe) begin
          if (stop) begin
            state_d = S_DONE;               // completed word is dropped
          end else begin
            push = 1'b1;
            if (last) begin
`ifdef SCAN_READER_LOOP_EN
              idx_d   = '0;
              state_d = full_next ? S_STALL : S_ISSUE;
`else
              idx_d   = idx_inc;
              state_d = S_DONE;
`endif
            end else begin
              idx_d   = idx_inc;
              state_d = full_next ? S_STALL : S_ISSUE;
            end
          end
        end else begin
          req_d = 1'b1;                     // arbiter cannot cancel: hold it
          if (stop) state_d = S_DRAIN;
        end
      end
      S_STALL: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (count_q != CW'(FIFO_DEPTH)) begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (read_finished_strobe) state_d = S_DONE;
        else                      req_d   = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= read_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && !out_valid));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                                   !(push && (count_q == CW'(FIFO_DEPTH)) && !pop));
endmodule

// File: tb/tb_sram_scan_reader.sv
// Randomised bench for sram_scan_reader: arbiter model with fixed latency,
// a word-level reference (expected address sequence and word queue) and a
// consumer with selectable ready behaviour.
module tb_sram_scan_reader;
  localparam int AW = 12, DW = 16, DEPTH = 4, LAT = 3;

  logic          clk = 0, rst = 1, start = 0, stop = 0;
  logic [AW-1:0] start_address = '0, length = '0, read_address;
  logic          read_request, read_finished_strobe = 0;
  logic [DW-1:0] read_data = '0, out_data;
  logic          out_valid, out_ready = 0, busy, done;

  sram_scan_reader #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .start_address(start_address), .length(length),
    .read_address(read_address), .read_request(read_request),
    .read_finished_strobe(read_finished_strobe), .read_data(read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference state
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] q [$];
  logic [AW-1:0] m_base = '0;
  int            m_len = 0, n_rd = 0, reads = 0, pops = 0, done_cnt = 0;
  int            cyc = 0, strobe_cyc = 0, done_cyc = 0, rdy_mode = 0;
  bit            abort_pend = 0;
  logic          req_s = 0;
  logic [AW-1:0] addr_s = '0, held = '0;
  int            cnt = 0;

  // arbiter: completes a request LAT cycles after it rises
  initial forever begin
    @(negedge clk);
    cyc++;
    req_s  = read_request;
    addr_s = read_address;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rst) begin
      read_finished_strobe = 0;
      cnt = 0;
    end else if (read_finished_strobe) begin
      read_finished_strobe = 0;
      chk("req_gap", read_request, 0);
    end else if (read_request) begin
      if (cnt == 0) held = read_address;
      cnt++;
      if (cnt == LAT) begin
        cnt = 0;
        chk("addr_stable", read_address, held);
        read_finished_strobe = 1;
        read_data = mem[read_address];
      end
    end
  end

  // reference: the k-th completed read must target base + k (mod len when looping)
  initial forever begin
    int k;
    logic [AW-1:0] ea;
    @(posedge clk);
    if (!rst && read_finished_strobe && req_s) begin
`ifdef SCAN_READER_LOOP_EN
      k = n_rd % m_len;
`else
      k = n_rd;
      chk("read_in_range", n_rd < m_len, 1);
`endif
      ea = m_base + k[AW-1:0];
      chk("addr", addr_s, ea);
      n_rd++; reads++; strobe_cyc = cyc;
      if (stop || abort_pend) abort_pend = 0;
      else q.push_back(mem[ea]);
    end else if (!rst && stop && req_s) begin
      abort_pend = 1;
    end
  end

  // consumer
  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = 0;
      1:       out_ready = 1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst && out_ready) begin
      if (q.size() == 0) chk("model_has_word", out_valid, 0);
      else if (out_valid) begin
        chk("out_data", out_data, q.pop_front());
        pops++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic scan(input logic [AW-1:0] b, input logic [AW-1:0] l);
    m_base = b; m_len = l; n_rd = 0; abort_pend = 0;
    start_address = b; length = l; start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin step(); t++; end
    chk("done_seen", done_cnt != d0, 1);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    rdy_mode = 1;
    while (out_valid && t < budget) begin step(); t++; end
    step();
    chk("drain_empty", out_valid, 0);
    chk("drain_model", q.size(), 0);
  endtask

  task automatic wait_req(input int budget);
    int t = 0;
    while (!read_request && t < budget) begin step(); t++; end
    chk("req_seen", read_request, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, r0, p0, t, l, k;
    logic [AW-1:0] b;
    bit do_stop;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    step(3);
    chk("rst_req",   read_request, 0);
    chk("rst_addr",  read_address, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    rst = 0;
    step(2);

`ifdef SCAN_READER_LOOP_EN
    rdy_mode = 1; d0 = done_cnt; r0 = reads;
    scan(12'h100, 2);
    t = 0;
    while (reads - r0 < 6 && t < 200) begin step(); t++; end
    chk("loop_progress", reads - r0 >= 6, 1);
    chk("loop_busy", busy, 1);
    chk("loop_no_done", done_cnt - d0, 0);
    stop = 1; step(); stop = 0;
    wait_done(d0, 50);
    step(3);
    chk("loop_done_once", done_cnt - d0, 1);
    chk("loop_idle", busy, 0);
    drain(50);
`else
    // basic three-word scan
    rdy_mode = 1; d0 = done_cnt; r0 = reads;
    scan(12'h010, 3);
    chk("t1_first_req", read_request, 1);
    wait_done(d0, 100);
    chk("t1_done_after_strobe", done_cyc - strobe_cyc, 1);
    step(3);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_reads", reads - r0, 3);
    chk("t1_idle", busy, 0);
    drain(20);

    // FIFO fills and stalls, then resumes
    rdy_mode = 0; d0 = done_cnt; r0 = reads;
    scan(12'h040, 8);
    step(40);
    chk("t2_reads_stalled", reads - r0, DEPTH);
    chk("t2_req_low", read_request, 0);
    chk("t2_busy", busy, 1);
    chk("t2_valid", out_valid, 1);
    rdy_mode = 1;
    wait_done(d0, 200);
    chk("t2_reads", reads - r0, 8);
    step(2);
    drain(50);

    // address wrap
    rdy_mode = 1; d0 = done_cnt; r0 = reads;
    scan(12'hFFE, 4);
    wait_done(d0, 100);
    chk("t3_reads", reads - r0, 4);
    step(2);
    drain(20);

    // stop while a request is outstanding
    rdy_mode = 0; d0 = done_cnt; r0 = reads; p0 = pops;
    scan(12'h200, 6);
    t = 0;
    while (!(reads - r0 == 2 && read_request) && t < 100) begin step(); t++; end
    chk("t4_second_gap_done", reads - r0, 2);
    stop = 1; step(); stop = 0;
    chk("t4_req_held", read_request, 1);
    wait_done(d0, 50);
    chk("t4_done_after_strobe", done_cyc - strobe_cyc, 1);
    chk("t4_reads", reads - r0, 3);
    step(2);
    chk("t4_fifo_kept", out_valid, 1);
    drain(20);
    chk("t4_pops", pops - p0, 2);

    // zero length
    d0 = done_cnt; r0 = reads;
    scan(12'h123, 0);
    chk("t5_done", done, 1);
    chk("t5_no_req", read_request, 0);
    step(3);
    chk("t5_reads", reads - r0, 0);
    chk("t5_done_once", done_cnt - d0, 1);

    // start and stop together in IDLE: start wins
    rdy_mode = 1; d0 = done_cnt; r0 = reads;
    stop = 1;
    scan(12'h500, 3);
    stop = 0;
    wait_done(d0, 100);
    chk("t6_reads", reads - r0, 3);
    step(2);
    drain(20);

    // randomised scans with random back-pressure and occasional stop
    for (int it = 0; it < 10; it++) begin
      b = AW'($urandom);
      l = $urandom_range(1, 10);
      do_stop = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 30);
      rdy_mode = 2; d0 = done_cnt; r0 = reads;
      scan(b, AW'(l));
      if (do_stop) begin
        step(k);
        if (done_cnt == d0) begin stop = 1; step(); stop = 0; end
      end
      wait_done(d0, 400);
      step(3);
      chk("rand_done_once", done_cnt - d0, 1);
      if (!do_stop) chk("rand_reads", reads - r0, l);
      drain(100);
    end

    // reset in the middle of a scan
    rdy_mode = 0;
    scan(12'h300, 5);
    wait_req(50);
    rst = 1;
    #1;
    chk("t8_req_async", read_request, 0);
    chk("t8_busy", busy, 0);
    chk("t8_valid", out_valid, 0);
    step(2);
    q.delete();
    abort_pend = 0;
    rst = 0;
    step(3);
    chk("t8_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
